// File: rtl/jstk2_spi_poller.sv
// jstk2_spi_poller: PmodJSTK2 SPI mode-0 master that polls 5-byte frames and decodes X/Y/buttons.
module jstk2_spi_poller #(
  parameter int SCLK_DIV  = 750,
  parameter int SS_LEAD   = 1500,
  parameter int BYTE_GAP  = 1000,
  parameter int FRAME_GAP = 1000000,
  parameter int AUTO_POLL = 1,
  parameter int OUT_W     = 11,
  parameter int SWAP_XY   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [39:0]      tx_cmd,
  input  logic             MISO,
  output logic             SS,
  output logic             SCLK,
  output logic             MOSI,
  output logic [OUT_W-1:0] x_val,
  output logic [OUT_W-1:0] y_val,
  output logic [1:0]       btn,
  output logic             frame_vld,
  output logic             busy
);
  localparam int M1 = 2 * SCLK_DIV > SS_LEAD ? 2 * SCLK_DIV : SS_LEAD;
  localparam int M2 = BYTE_GAP > FRAME_GAP ? BYTE_GAP : FRAME_GAP;
  localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);
  localparam logic [CW-1:0] LEAD_END = CW'(SS_LEAD - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(BYTE_GAP - 1);
  localparam logic [CW-1:0] IDLE_END = CW'(FRAME_GAP - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(2 * SCLK_DIV - 1);
  localparam logic [CW-1:0] RISE     = CW'(SCLK_DIV);
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, GAP, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt, byte_idx;
  logic [39:0] tx_sr, rx_sr;
  logic [9:0] raw_x, raw_y;
  logic bit_end, unused_bits;
  assign bit_end = state == SHIFT && cnt == BIT_END;
  assign raw_x = {rx_sr[25:24], rx_sr[39:32]};
  assign raw_y = {rx_sr[9:8], rx_sr[23:16]};
  assign unused_bits = ^{rx_sr[31:26], rx_sr[15:10], rx_sr[7:2]};
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = (AUTO_POLL != 0 ? cnt == IDLE_END : start) ? LEAD : IDLE;
      LEAD:    nxt = cnt == LEAD_END ? SHIFT : LEAD;
      SHIFT:   nxt = bit_end && bit_cnt == 3'd7 ? (byte_idx == 3'd4 ? DONE : GAP) : SHIFT;
      GAP:     nxt = cnt == GAP_END ? SHIFT : GAP;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // cnt restarts on every phase change and every bit; manual idle never counts
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      x_val    <= '0;
      y_val    <= '0;
      btn      <= '0;
    end else begin
      cnt <= (nxt != state || bit_end || (state == IDLE && AUTO_POLL == 0)) ? '0 : cnt + 1'b1;
      if (state == IDLE) begin
        tx_sr    <= tx_cmd;
        bit_cnt  <= '0;
        byte_idx <= '0;
      end
      if (state == SHIFT && cnt == RISE) rx_sr <= {rx_sr[38:0], MISO};
      if (bit_end) begin
        tx_sr   <= {tx_sr[38:0], 1'b0};
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == 3'd7) byte_idx <= byte_idx + 1'b1;
      end
      if (nxt == DONE) begin
        x_val <= OUT_W'(SWAP_XY != 0 ? raw_y : raw_x);
        y_val <= OUT_W'(SWAP_XY != 0 ? raw_x : raw_y);
        btn   <= rx_sr[1:0];
      end
    end
  end
  always_comb begin
    SS        = state == IDLE || state == DONE;
    SCLK      = state == SHIFT && cnt >= RISE;
    MOSI      = !SS && tx_sr[39];
    frame_vld = state == DONE;
    busy      = state != IDLE;
  end
endmodule
